// File: rtl/seq_pattern_tx.sv
// Serial frame transmitter: shifts a loaded word onto a 1-bit line and keeps
// a saturating count of overlapping "101" patterns seen on that line.
module seq_pattern_tx #(
  parameter int DATA_W    = 8,
  parameter int CNT_W     = 8,
  parameter int GAP_CYC   = 0,
  parameter int MSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_valid,
  output logic              load_ready,
  output logic              out,
  output logic              out_valid,
  output logic              done,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  match_cnt
);

  localparam int BIT_W = $clog2(DATA_W);
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0] PRE_LAST = BIT_W'(DATA_W - 2);
  localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'((GAP_CYC > 0) ? (GAP_CYC - 1) : 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t             r_state;
  logic [DATA_W-1:0]  r_shift;
  logic [BIT_W-1:0]   r_bit_cnt;
  logic [GAP_W-1:0]   r_gap_cnt;
  logic               r_ready;
  logic               r_out;
  logic               r_valid;
  logic               r_done;
  logic [1:0]         r_hist;
  logic [CNT_W-1:0]   r_cnt;

  logic [DATA_W-1:0]  w_next_shift;
  logic               w_next_bit;
  logic               w_first_bit;
  logic               w_match;

  // The head of the shift register is always the bit on the line.
  assign w_next_shift = (MSB_FIRST != 0) ? {r_shift[DATA_W-2:0], 1'b0}
                                         : {1'b0, r_shift[DATA_W-1:1]};
  assign w_next_bit   = (MSB_FIRST != 0) ? w_next_shift[DATA_W-1] : w_next_shift[0];
  assign w_first_bit  = (MSB_FIRST != 0) ? load_data[DATA_W-1] : load_data[0];
  assign w_match      = (r_hist == 2'b10) && r_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_gap_cnt <= '0;
      r_ready   <= 1'b1;
      r_out     <= 1'b0;
      r_valid   <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (load_valid) begin
            r_state   <= SHIFT;
            r_shift   <= load_data;
            r_bit_cnt <= '0;
            r_out     <= w_first_bit;
            r_valid   <= 1'b1;
            r_done    <= 1'b0;
            r_ready   <= 1'b0;
          end
        end
        SHIFT: begin
          if (r_bit_cnt == LAST_BIT) begin
            r_out   <= 1'b0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            if (GAP_CYC > 0) begin
              r_state   <= GAP;
              r_gap_cnt <= '0;
              r_ready   <= 1'b0;
            end else begin
              r_state <= IDLE;
              r_ready <= 1'b1;
            end
          end else begin
            r_shift   <= w_next_shift;
            r_bit_cnt <= r_bit_cnt + 1'b1;
            r_out     <= w_next_bit;
            r_done    <= (r_bit_cnt == PRE_LAST);
          end
        end
        GAP: begin
          if (r_gap_cnt == LAST_GAP) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  // History sees idle zeros too, so patterns can span frame boundaries.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hist <= 2'b00;
      r_cnt  <= '0;
    end else begin
      r_hist <= {r_hist[0], r_out};
      if (cnt_clr)
        r_cnt <= '0;
      else if (w_match && (r_cnt != CNT_MAX))
        r_cnt <= r_cnt + 1'b1;
    end
  end

  assign load_ready = r_ready;
  assign out        = r_out;
  assign out_valid  = r_valid;
  assign done       = r_done;
  assign match_cnt  = r_cnt;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx: three instances cover the default build,
// a 2-bit saturating counter, and LSB-first order with an inter-frame gap.
module tb_seq_pattern_tx;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;

  // Instance 0: defaults
  logic [7:0] d0 = '0;
  logic v0 = 0, c0 = 0, rdy0, o0, ov0, dn0;
  logic [7:0] mc0;
  // Instance 1: CNT_W=2
  logic [7:0] d1 = '0;
  logic v1 = 0, c1 = 0, rdy1, o1, ov1, dn1;
  logic [1:0] mc1;
  // Instance 2: LSB first, GAP_CYC=3
  logic [7:0] d2 = '0;
  logic v2 = 0, c2 = 0, rdy2, o2, ov2, dn2;
  logic [7:0] mc2;

  seq_pattern_tx #(.DATA_W(8), .CNT_W(8), .GAP_CYC(0), .MSB_FIRST(1)) u0 (
    .clk(clk), .rst(rst), .load_data(d0), .load_valid(v0), .load_ready(rdy0),
    .out(o0), .out_valid(ov0), .done(dn0), .cnt_clr(c0), .match_cnt(mc0));
  seq_pattern_tx #(.DATA_W(8), .CNT_W(2), .GAP_CYC(0), .MSB_FIRST(1)) u1 (
    .clk(clk), .rst(rst), .load_data(d1), .load_valid(v1), .load_ready(rdy1),
    .out(o1), .out_valid(ov1), .done(dn1), .cnt_clr(c1), .match_cnt(mc1));
  seq_pattern_tx #(.DATA_W(8), .CNT_W(8), .GAP_CYC(3), .MSB_FIRST(0)) u2 (
    .clk(clk), .rst(rst), .load_data(d2), .load_valid(v2), .load_ready(rdy2),
    .out(o2), .out_valid(ov2), .done(dn2), .cnt_clr(c2), .match_cnt(mc2));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [7:0] s_out, s_val, s_done, s_rdy;
  logic [2:0] g_rdy, g_val;

  initial begin
    // Reset
    #1;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    chk("rst_ready", {31'd0, rdy0}, 32'd1);
    chk("rst_out",   {29'd0, o0, ov0, dn0}, 32'd0);
    chk("rst_cnt",   {24'd0, mc0}, 32'd0);

    // T1: 8'hAA MSB first
    d0 = 8'hAA; v0 = 1'b1;
    step();
    v0 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      s_out  = {s_out[6:0], o0};
      s_val  = {s_val[6:0], ov0};
      s_done = {s_done[6:0], dn0};
      step();
    end
    chk("t1_bits",  {24'd0, s_out},  32'hAA);
    chk("t1_valid", {24'd0, s_val},  32'hFF);
    chk("t1_done",  {24'd0, s_done}, 32'h01);
    chk("t1_cnt",   {24'd0, mc0},    32'd3);
    chk("t1_idle",  {30'd0, rdy0, ov0}, 32'b10);

    // T2: A5 then 80 at first ready; clear counter at the A5 accept edge
    d0 = 8'hA5; v0 = 1'b1; c0 = 1'b1;
    step();
    v0 = 1'b0; c0 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      s_out = {s_out[6:0], o0};
      step();
    end
    chk("t2_bits_a5", {24'd0, s_out}, 32'hA5);
    chk("t2_gap",     {30'd0, rdy0, ov0}, 32'b10);
    d0 = 8'h80; v0 = 1'b1;
    step();
    v0 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      s_out = {s_out[6:0], o0};
      step();
    end
    chk("t2_bits_80", {24'd0, s_out}, 32'h80);
    chk("t2_cnt",     {24'd0, mc0}, 32'd3);

    // T3: load_valid held high, data changed during SHIFT
    d0 = 8'hC3; v0 = 1'b1;
    step();
    d0 = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      s_out = {s_out[6:0], o0};
      s_rdy = {s_rdy[6:0], rdy0};
      step();
    end
    chk("t3_bits_c3", {24'd0, s_out}, 32'hC3);
    chk("t3_ready",   {24'd0, s_rdy}, 32'h00);
    chk("t3_idle",    {30'd0, rdy0, ov0}, 32'b10);
    step();
    v0 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      s_out = {s_out[6:0], o0};
      step();
    end
    chk("t3_bits_ff", {24'd0, s_out}, 32'hFF);
    step(); step();

    // T6: reset in the middle of a frame (at bit index 4)
    d0 = 8'hAA; v0 = 1'b1; c0 = 1'b1;
    step();
    v0 = 1'b0; c0 = 1'b0;
    step(); step(); step(); step();
    chk("t6_pre_cnt", {24'd0, mc0}, 32'd1);
    chk("t6_pre_out", {30'd0, ov0, o0}, 32'b11);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_rst_line", {29'd0, o0, ov0, dn0}, 32'd0);
    chk("t6_rst_cnt",  {24'd0, mc0}, 32'd0);
    chk("t6_rst_rdy",  {31'd0, rdy0}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      s_done = {s_done[6:0], dn0};
      s_val  = {s_val[6:0], ov0};
      step();
    end
    chk("t6_no_done", {16'd0, s_done, s_val}, 32'd0);

    // T4: CNT_W=2 saturation and clear-wins
    d1 = 8'hAA; v1 = 1'b1;
    step();
    v1 = 1'b0;
    for (int i = 0; i < 8; i++) step();
    chk("t4_cnt_first", {30'd0, mc1}, 32'd3);
    v1 = 1'b1;
    step();
    v1 = 1'b0;
    for (int i = 0; i < 8; i++) step();
    chk("t4_cnt_sat", {30'd0, mc1}, 32'd3);
    v1 = 1'b1;
    step();
    v1 = 1'b0;
    step(); step();
    chk("t4_match_bit", {31'd0, o1}, 32'd1);
    c1 = 1'b1;
    step();
    c1 = 1'b0;
    chk("t4_clr", {30'd0, mc1}, 32'd0);
    step(); step();
    chk("t4_after_clr", {30'd0, mc1}, 32'd1);
    for (int i = 0; i < 4; i++) step();

    // T5: LSB first with 3-cycle gap
    d2 = 8'h01; v2 = 1'b1;
    step();
    v2 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      s_out  = {s_out[6:0], o2};
      s_done = {s_done[6:0], dn2};
      s_rdy  = {s_rdy[6:0], rdy2};
      step();
    end
    chk("t5_bits", {24'd0, s_out},  32'h80);
    chk("t5_done", {24'd0, s_done}, 32'h01);
    chk("t5_rdy",  {24'd0, s_rdy},  32'h00);
    for (int i = 0; i < 3; i++) begin
      g_rdy = {g_rdy[1:0], rdy2};
      g_val = {g_val[1:0], ov2};
      step();
    end
    chk("t5_gap", {26'd0, g_rdy, g_val}, 32'd0);
    chk("t5_ready_back", {30'd0, rdy2, ov2}, 32'b10);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
